// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared core constants and flattened-port slice helpers
package rv_pkg;

   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int REG_ZERO = 0;

   // Low bit of lane idx in a flattened bus of lanes w bits wide.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

   // High bit of lane idx in a flattened bus of lanes w bits wide.
   function automatic int slice_hi(input int idx, input int w);
      return (idx * w) + w - 1;
   endfunction

endpackage

// File: rtl/sb_tracker.sv
// rtl/sb_tracker.sv - busy-bit scoreboard with incremental pending count
module sb_tracker
   import rv_pkg::*;
#(
   parameter int NREGS  = rv_pkg::NREGS,
   parameter int NUM_RD = 2,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = $clog2(NREGS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   input  logic                 we,
   input  logic [AW-1:0]        wr_addr,
   input  logic                 mark_en,
   input  logic [AW-1:0]        mark_addr,
   input  logic                 flush,
   output logic [NUM_RD-1:0]    rd_busy,
   output logic [CW-1:0]        pending_cnt,
   output logic                 any_busy
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             wr_hit;
   logic             mk_hit;
   logic             inc;
   logic             dec;

   // Next busy vector and count: flush beats everything, a mark beats a same-address write.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = pending_cnt;
      wr_hit   = we && (wr_addr != AW'(REG_ZERO));
      mk_hit   = mark_en && (mark_addr != AW'(REG_ZERO));
      inc      = mk_hit && !busy[mark_addr];
      dec      = wr_hit && busy[wr_addr] && !(mk_hit && (mark_addr == wr_addr));
      if (flush) begin
         busy_nxt = '0;
         cnt_nxt  = '0;
      end else begin
         if (wr_hit) busy_nxt[wr_addr] = 1'b0;
         if (mk_hit) busy_nxt[mark_addr] = 1'b1;
         if (inc && !dec)      cnt_nxt = pending_cnt + CW'(1);
         else if (dec && !inc) cnt_nxt = pending_cnt - CW'(1);
      end
   end

   // Scoreboard state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy        <= '0;
         pending_cnt <= '0;
      end else begin
         busy        <= busy_nxt;
         pending_cnt <= cnt_nxt;
      end
   end

   // A register being written this cycle is not busy: its data is bypassed.
   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_busy[i] = busy[rd_addr[i*AW +: AW]]
                      && (rd_addr[i*AW +: AW] != AW'(REG_ZERO))
                      && !(we && (wr_addr == rd_addr[i*AW +: AW]));
      end
   end

   assign any_busy = (pending_cnt != '0);

endmodule

// File: rtl/reg_bank_sb.sv
// rtl/reg_bank_sb.sv - register bank with write bypass and busy-bit scoreboard
module reg_bank_sb
   import rv_pkg::*;
#(
   parameter int XLEN   = rv_pkg::XLEN,
   parameter int NREGS  = rv_pkg::NREGS,
   parameter int NUM_RD = 2,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = $clog2(NREGS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   input  logic                   we,
   input  logic [AW-1:0]          wr_addr,
   input  logic [XLEN-1:0]        wr_data,
   input  logic                   mark_en,
   input  logic [AW-1:0]          mark_addr,
   input  logic                   flush,
   output logic [CW-1:0]          pending_cnt,
   output logic                   any_busy
);

   logic [XLEN-1:0] regs [NREGS];
   logic [AW-1:0]   ra;

   // Data array write; x0 is never written so it stays zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (we && (wr_addr != AW'(REG_ZERO))) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read muxes: x0 reads zero, then same-cycle write bypass, then the array; forced to zero in reset.
   always_comb begin
      rd_data = '0;
      ra      = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra = rd_addr[i*AW +: AW];
         if (reset || (ra == AW'(REG_ZERO)))
            rd_data[i*XLEN +: XLEN] = '0;
         else if (we && (wr_addr == ra))
            rd_data[i*XLEN +: XLEN] = wr_data;
         else
            rd_data[i*XLEN +: XLEN] = regs[ra];
      end
   end

   sb_tracker #(
      .NREGS  (NREGS),
      .NUM_RD (NUM_RD)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (rd_addr),
      .we          (we),
      .wr_addr     (wr_addr),
      .mark_en     (mark_en),
      .mark_addr   (mark_addr),
      .flush       (flush),
      .rd_busy     (rd_busy),
      .pending_cnt (pending_cnt),
      .any_busy    (any_busy)
   );

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb/tb_reg_bank_sb.sv - directed self-checking bench for reg_bank_sb
module tb_reg_bank_sb;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NUM_RD = 2;
   localparam int AW     = 5;
   localparam int CW     = 6;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic                   we;
   logic [AW-1:0]          wr_addr;
   logic [XLEN-1:0]        wr_data;
   logic                   mark_en;
   logic [AW-1:0]          mark_addr;
   logic                   flush;
   logic [CW-1:0]          pending_cnt;
   logic                   any_busy;

   int checks = 0;
   int errors = 0;

   reg_bank_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .we          (we),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .mark_en     (mark_en),
      .mark_addr   (mark_addr),
      .flush       (flush),
      .pending_cnt (pending_cnt),
      .any_busy    (any_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; wr_addr = '0; wr_data = '0;
      mark_en = 1'b0; mark_addr = '0; flush = 1'b0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      rd_addr = '0;
      tick();
      tick();
      set_rd(5'd5, 5'd7);
      check("por_cnt", 64'(pending_cnt), 64'd0);
      check("por_any", 64'(any_busy), 64'd0);
      check("por_data", 64'(rd_data), 64'd0);
      check("por_busy", 64'(rd_busy), 64'd0);
      reset = 1'b0;

      // reset mid-run
      we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      tick();
      idle(); mark_en = 1'b1; mark_addr = 5'd7;
      tick();
      idle();
      set_rd(5'd5, 5'd7);
      check("pre_rst_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
      check("pre_rst_busy", 64'(rd_busy), 64'b10);
      check("pre_rst_cnt", 64'(pending_cnt), 64'd1);
      reset = 1'b1;
      #1;
      check("rst_data", 64'(rd_data[31:0]), 64'd0);
      check("rst_busy", 64'(rd_busy), 64'd0);
      check("rst_cnt", 64'(pending_cnt), 64'd0);
      check("rst_any", 64'(any_busy), 64'd0);
      tick();
      reset = 1'b0;

      // x0 protection
      we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      mark_en = 1'b1; mark_addr = 5'd0;
      set_rd(5'd0, 5'd0);
      check("x0_same", 64'(rd_data[31:0]), 64'd0);
      tick();
      idle();
      set_rd(5'd0, 5'd0);
      check("x0_after", 64'(rd_data[31:0]), 64'd0);
      check("x0_cnt", 64'(pending_cnt), 64'd0);

      // write bypass
      we = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
      tick();
      wr_data = 32'h22;
      set_rd(5'd3, 5'd3);
      check("byp_same0", 64'(rd_data[31:0]), 64'h22);
      check("byp_same1", 64'(rd_data[63:32]), 64'h22);
      tick();
      idle();
      set_rd(5'd3, 5'd0);
      check("byp_next", 64'(rd_data[31:0]), 64'h22);

      // write to a non-busy register leaves the count alone
      we = 1'b1; wr_addr = 5'd6; wr_data = 32'h6;
      tick();
      idle();
      #1;
      check("nobusy_wr_cnt", 64'(pending_cnt), 64'd0);

      // scoreboard lifecycle
      mark_en = 1'b1; mark_addr = 5'd4;
      set_rd(5'd4, 5'd0);
      check("mark_same_cycle", 64'(rd_busy[0]), 64'd0);
      tick();
      idle();
      set_rd(5'd4, 5'd0);
      check("life_busy", 64'(rd_busy[0]), 64'd1);
      check("life_cnt1", 64'(pending_cnt), 64'd1);
      check("life_any", 64'(any_busy), 64'd1);
      tick();
      we = 1'b1; wr_addr = 5'd4; wr_data = 32'h99;
      #1;
      check("life_wr_busy", 64'(rd_busy[0]), 64'd0);
      check("life_wr_data", 64'(rd_data[31:0]), 64'h99);
      check("life_wr_cnt", 64'(pending_cnt), 64'd1);
      tick();
      idle();
      #1;
      check("life_cnt0", 64'(pending_cnt), 64'd0);
      check("life_any0", 64'(any_busy), 64'd0);

      // case A: mark and write same busy register
      mark_en = 1'b1; mark_addr = 5'd8;
      tick();
      we = 1'b1; wr_addr = 5'd8; wr_data = 32'h1;
      tick();
      idle();
      set_rd(5'd8, 5'd0);
      check("caseA_busy", 64'(rd_busy[0]), 64'd1);
      check("caseA_cnt", 64'(pending_cnt), 64'd1);

      // case B: busy moves x9 -> x10
      mark_en = 1'b1; mark_addr = 5'd9;
      tick();
      idle();
      #1;
      check("caseB_pre_cnt", 64'(pending_cnt), 64'd2);
      mark_en = 1'b1; mark_addr = 5'd10;
      we = 1'b1; wr_addr = 5'd9; wr_data = 32'h9;
      tick();
      idle();
      set_rd(5'd9, 5'd10);
      check("caseB_cnt", 64'(pending_cnt), 64'd2);
      check("caseB_busy", 64'(rd_busy), 64'b10);

      // flush
      flush = 1'b1;
      tick();
      idle();
      for (int r = 1; r <= 3; r++) begin
         mark_en = 1'b1; mark_addr = AW'(r);
         tick();
      end
      idle();
      set_rd(5'd2, 5'd3);
      check("fl_cnt3", 64'(pending_cnt), 64'd3);
      flush = 1'b1; we = 1'b1; wr_addr = 5'd1; wr_data = 32'h5;
      mark_en = 1'b1; mark_addr = 5'd12;
      #1;
      check("fl_nomask", 64'(rd_busy), 64'b11);
      tick();
      idle();
      set_rd(5'd1, 5'd2);
      check("fl_cnt0", 64'(pending_cnt), 64'd0);
      check("fl_any0", 64'(any_busy), 64'd0);
      check("fl_busy", 64'(rd_busy), 64'd0);
      check("fl_data", 64'(rd_data[31:0]), 64'h5);
      set_rd(5'd12, 5'd3);
      check("fl_mark_ign", 64'(rd_busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
- Parametrised successor to the single-cycle register bank for the RISC-V core.
- Clocked write port, NUM_RD combinational read ports with write-to-read bypass, and x0 hardwired to zero.
- Integrated busy-bit scoreboard that tracks registers with in-flight producers (loads, multi-cycle ALU ops) so the hazard unit can stall.
- Sits between the decode stage (reads, marks) and the writeback stage (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width (derived localparam).
- NUM_RD, 2, number of read ports; range 1..4.
- CW, $clog2(NREGS+1), pending-count width (derived localparam).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  per-port flag: the addressed register has a pending producer.
- we  in  1  writeback enable.
- wr_addr  in  AW  writeback register address.
- wr_data  in  XLEN  writeback data.
- mark_en  in  1  decode issues an instruction whose result arrives later.
- mark_addr  in  AW  destination register of that instruction.
- flush  in  1  pipeline flush; discard all pending marks.
- pending_cnt  out  CW  number of busy bits currently set.
- any_busy  out  1  asserted when pending_cnt != 0.

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high.
- On reset assertion, immediately and for its whole duration:
  - all NREGS registers = 0, all busy bits = 0, pending_cnt = 0;
  - so any_busy = 0, rd_busy = 0 and rd_data = 0 on every port.
- Reset deasserted mid-operation: state restarts from all-zero. Writes and marks presented during reset are lost.
- Write: at posedge clk, if we=1 and wr_addr!=0, then regs[wr_addr] <= wr_data. A write to address 0 is ignored.
- Read is combinational, zero latency, per port i:
  - rd_addr_i==0 gives 0, regardless of we or wr_addr;
  - else if we=1 and wr_addr==rd_addr_i, gives wr_data (same-cycle bypass);
  - else gives regs[rd_addr_i].
- Multiple read ports may address the same register and all return identical data.
- Scoreboard update at posedge clk, in priority order:
  1. flush=1: all busy bits <= 0 and pending_cnt <= 0. The data write still occurs; mark_en is ignored.
  2. Otherwise, write clear: if we=1 and wr_addr!=0, busy[wr_addr] <= 0.
  3. Otherwise, mark set: if mark_en=1 and mark_addr!=0, busy[mark_addr] <= 1. When mark_addr==wr_addr in the same cycle, the mark wins and the bit ends at 1 (a new producer supersedes the returning one).
- Register 0 is never busy.
- A mark on an already-busy register leaves the bit at 1 with no count change.
- A write to a non-busy register changes no bit and no count.
- pending_cnt is maintained incrementally and never equals a recomputed popcount off by one. Next value =
  - current count,
  - +1 if the mark sets a bit that was 0,
  - −1 if the write clears a bit that was 1 and the same-address mark does not re-set it.
- Both +1 and −1 in one cycle (different addresses) net to 0.
- pending_cnt never exceeds NREGS−1 and never underflows.
- rd_busy_i = busy[rd_addr_i] AND NOT (we=1 AND wr_addr==rd_addr_i). A register being written this cycle reads not-busy because its data is bypassed.
- rd_busy_i is 0 for address 0.
- A mark does not affect rd_busy in the same cycle; it is visible from the next cycle.
- flush does not mask rd_busy combinationally in its own cycle.
- Simulation: no X on any output after the first reset.

Decomposition:
- Shared package rv_pkg: XLEN, NREGS, REG_ZERO (address 0 constant), and the flattened-port slice helpers used by other multi-port blocks.
- One sub-module, sb_tracker: busy-bit vector, priority update, pending_cnt counter and the rd_busy mask.
- The data array, write logic and bypass muxes stay in reg_bank_sb.

Test Plan:
- Reset mid-run: write x5=0xDEADBEEF, then mark x7, then assert reset for 1 cycle. Required: x5 reads 0, rd_busy=0, pending_cnt=0, any_busy=0 while reset is still high.
- x0 protection: we=1, wr_addr=0, wr_data=0xFFFFFFFF, read port 0 addr 0, plus mark_addr=0. Required: rd_data0=0 in that cycle and after; pending_cnt stays 0.
- Bypass: port0 reads x3 holding 0x11 while we=1, wr_addr=3, wr_data=0x22 in the same cycle. Required: rd_data0=0x22 in that cycle and 0x22 in the next cycle with we=0.
- Scoreboard lifecycle: mark x4 in cycle 1. Required: rd_busy=1 and pending_cnt=1 in cycle 2. Write x4=0x99 in cycle 3 → rd_busy=0 and rd_data=0x99 within cycle 3; pending_cnt=0 in cycle 4.
- Simultaneous events:
  - case A: x8 busy; mark x8 and write x8 together. Required: busy[x8] stays 1, pending_cnt unchanged.
  - case B: x9 busy; mark x10 and write x9. Required: count unchanged, busy moves x9→x10.
- Flush: mark x1, x2, x3 on three cycles (pending_cnt=3), then flush with we to x1=0x5. Required: next cycle pending_cnt=0, all rd_busy=0, x1 reads 0x5.
